// File: rtl/async_fifo_reader.sv
// -----------------------------------------------------------------------------
// async_fifo_reader
//
// Read-side adapter for the dual-clock FIFO. Pops words from the FIFO read
// port and presents them as a registered valid/ready stream in the rclk
// domain. The FIFO only drives data_out during the cycle its ren is
// accepted, so every popped word is captured on that same edge into a
// 2-entry skid buffer. Downstream back-pressure is absorbed without bubbles.
//
// Optional feature macro: FIFO_READER_CNT_EN
//   When defined, the rd_count port exists and counts delivered words
//   (wrapping modulo 2^CNT_WIDTH). When undefined, the port and the counter
//   are absent and all other behaviour is identical.
//
// Parameters:
//   WIDTH      data word width (must match the FIFO WIDTH)
//   CNT_WIDTH  width of the delivered-word counter (FIFO_READER_CNT_EN only)
//
// Ports:
//   rclk        in   read-domain clock, rising edge
//   reset       in   asynchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, meaningful only while fifo_ren=1
//   fifo_ren    out  FIFO read enable; a pop happens on every edge it is 1
//   m_valid     out  output word valid
//   m_ready     in   consumer ready
//   m_data      out  output word (head of the skid buffer)
//   rd_count    out  delivered-word count (FIFO_READER_CNT_EN only)
// -----------------------------------------------------------------------------
module async_fifo_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_ren,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] rd_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             occ;
  logic [WIDTH-1:0] buf0;  // head word, drives m_data
  logic [WIDTH-1:0] buf1;  // skid word, filled only while the head is stalled
  logic             push;
  logic             pop;

  // The read request depends only on registered occupancy, the FIFO flag and
  // reset, so m_ready never reaches the FIFO combinationally. Keeping one
  // slot free whenever we ask guarantees the popped word always has a home.
  assign fifo_ren = !fifo_empty && (occ != TWO) && !reset;
  assign m_valid  = (occ != EMPTY);
  assign m_data   = buf0;

  assign push = fifo_ren;
  assign pop  = m_valid && m_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours (buf0 <= buf1
  // relies on this).
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      // NOTE: the data buffers are reset too, because m_data must read as
      // zero out of reset; they are two words, not a memory array.
      occ  <= EMPTY;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case (occ)
        EMPTY: begin
          if (push) begin
            buf0 <= fifo_data;
            occ  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Head leaves and the new word replaces it directly.
            buf0 <= fifo_data;
          end else if (push) begin
            buf1 <= fifo_data;
            occ  <= TWO;
          end else if (pop) begin
            occ <= EMPTY;
          end
        end
        TWO: begin
          // fifo_ren is low in TWO, so only a pop can happen here.
          if (pop) begin
            buf0 <= buf1;
            occ  <= ONE;
          end
        end
        default: begin
          // Unused encoding: fall back to a clean empty buffer.
          occ <= EMPTY;
        end
      endcase
    end
  end

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + 1'b1;  // wraps naturally at 2^CNT_WIDTH
    end
  end
`endif

endmodule
